// File: rtl/pwm_voice_mixer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pwm_voice_mixer
// Description : Eight square-wave voices from a shared prescaled tick, summed
//               and turned into a 1-bit PWM audio stream on an 8-cycle frame.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_voice_mixer #(
    parameter int PRESCALE   = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pwm_reg0,
    input  logic [15:0] pwm_reg1,
    input  logic [15:0] pwm_reg2,
    input  logic [15:0] pwm_reg3,
    input  logic [15:0] pwm_reg4,
    input  logic [15:0] pwm_reg5,
    input  logic [15:0] pwm_reg6,
    input  logic [15:0] pwm_reg7,
    output logic        audio_pwm,
    output logic [3:0]  mix_level,
    output logic        frame_start,
    output logic [7:0]  voice_active
);

    localparam logic [PRESCALE_W-1:0] c_PRE_MAX = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] c_PRE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic                  w_tick;
    logic [15:0]           w_reg [8];
    logic [3:0]            w_pop;
    logic [3:0]            r_mix_level;
    logic [2:0]            r_frm_cnt;
    logic [3:0]            r_lvl_lat;
    logic                  r_audio_pwm;

    assign w_reg[0] = pwm_reg0;
    assign w_reg[1] = pwm_reg1;
    assign w_reg[2] = pwm_reg2;
    assign w_reg[3] = pwm_reg3;
    assign w_reg[4] = pwm_reg4;
    assign w_reg[5] = pwm_reg5;
    assign w_reg[6] = pwm_reg6;
    assign w_reg[7] = pwm_reg7;

    assign w_tick = (r_pre_cnt == c_PRE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + c_PRE_ONE;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_voice
        logic        w_en;
        logic [14:0] w_hp;
        logic [14:0] r_cnt;
        logic        r_ph;

        assign w_en = w_reg[gi][15];
        assign w_hp = w_reg[gi][14:0];

        // Live control: a lowered half-period toggles on the next tick rather
        // than letting the counter run up through 2^15.
        always_ff @(posedge clk) begin
            if (rst || !w_en || (w_hp == 15'd0)) begin
                r_cnt <= '0;
                r_ph  <= 1'b0;
            end else if (w_tick) begin
                if (r_cnt >= (w_hp - 15'd1)) begin
                    r_cnt <= '0;
                    r_ph  <= ~r_ph;
                end else begin
                    r_cnt <= r_cnt + 15'd1;
                end
            end
        end

        assign voice_active[gi] = r_ph;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'b000, voice_active[i]};
        end
    end

    // Level is latched once per frame so each frame carries a whole duty value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mix_level <= '0;
            r_frm_cnt   <= '0;
            r_lvl_lat   <= '0;
            r_audio_pwm <= 1'b0;
        end else begin
            r_mix_level <= w_pop;
            r_frm_cnt   <= r_frm_cnt + 3'd1;
            if (r_frm_cnt == 3'd7) begin
                r_lvl_lat <= r_mix_level;
            end
            r_audio_pwm <= ({1'b0, r_frm_cnt} < r_lvl_lat);
        end
    end

    assign mix_level   = r_mix_level;
    assign audio_pwm   = r_audio_pwm;
    assign frame_start = (r_frm_cnt == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_pwm_voice_mixer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pwm_voice_mixer
// Description : Scoreboard bench for pwm_voice_mixer with directed timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_voice_mixer;

    localparam int PRESCALE = 4;

    typedef struct packed {
        logic [7:0] va;
        logic [3:0] mix;
        logic       fs;
        logic       aud;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] regs [8];
    logic        audio_pwm;
    logic [3:0]  mix_level;
    logic        frame_start;
    logic [7:0]  voice_active;

    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          k        = -1;
    int          fs_cnt   = 0;
    int          aud_cnt  = 0;

    int          m_pre;
    logic [14:0] m_cnt [8];
    logic [7:0]  m_ph;
    logic [2:0]  m_frm;
    logic [3:0]  m_lvl;
    logic [3:0]  m_mix;
    logic        m_aud;

    pwm_voice_mixer #(.PRESCALE(PRESCALE), .PRESCALE_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_reg0     (regs[0]),
        .pwm_reg1     (regs[1]),
        .pwm_reg2     (regs[2]),
        .pwm_reg3     (regs[3]),
        .pwm_reg4     (regs[4]),
        .pwm_reg5     (regs[5]),
        .pwm_reg6     (regs[6]),
        .pwm_reg7     (regs[7]),
        .audio_pwm    (audio_pwm),
        .mix_level    (mix_level),
        .frame_start  (frame_start),
        .voice_active (voice_active)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s clock=%0d got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge; pushes the post-edge outputs.
    task automatic model_edge();
        exp_t        e;
        logic        tick;
        logic [3:0]  pc;
        if (rst) begin
            m_pre = 0; m_ph = '0; m_frm = '0; m_lvl = '0; m_mix = '0; m_aud = 1'b0;
            for (int i = 0; i < 8; i++) m_cnt[i] = '0;
        end else begin
            tick = (m_pre == PRESCALE - 1);
            pc = '0;
            for (int i = 0; i < 8; i++) pc = pc + {3'b000, m_ph[i]};
            m_aud = ({1'b0, m_frm} < m_lvl);
            if (m_frm == 3'd7) m_lvl = m_mix;
            m_mix = pc;
            m_frm = m_frm + 3'd1;
            for (int i = 0; i < 8; i++) begin
                if (!regs[i][15] || regs[i][14:0] == 15'd0) begin
                    m_cnt[i] = '0;
                    m_ph[i]  = 1'b0;
                end else if (tick) begin
                    if (int'(m_cnt[i]) + 1 >= int'(regs[i][14:0])) begin
                        m_cnt[i] = '0;
                        m_ph[i]  = ~m_ph[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] + 15'd1;
                    end
                end
            end
            m_pre = tick ? 0 : m_pre + 1;
        end
        e.va  = m_ph;
        e.mix = m_mix;
        e.fs  = (m_frm == 3'd0);
        e.aud = m_aud;
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        k = rst ? -1 : k + 1;
        #1;
        e = sb_q.pop_front();
        check_val("voice_active", 32'(voice_active), 32'(e.va));
        check_val("mix_level",    32'(mix_level),    32'(e.mix));
        check_val("frame_start",  32'(frame_start),  32'(e.fs));
        check_val("audio_pwm",    32'(audio_pwm),    32'(e.aud));
        fs_cnt  += int'(frame_start);
        aud_cnt += int'(audio_pwm);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic find_edge(input int b, input logic lvl, input int max, output int at);
        at = -1;
        for (int n = 0; n < max; n++) begin
            step();
            if (voice_active[b] === lvl) begin
                at = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_va",  32'(voice_active), 32'h0);
        check_val("rst_mix", 32'(mix_level),    32'h0);
        check_val("rst_aud", 32'(audio_pwm),    32'h0);
        check_val("rst_fs",  32'(frame_start),  32'h1);
    endtask

    initial begin
        int at;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;

        // Idle: silence and a frame_start every 8 clocks
        do_reset();
        fs_cnt = 0; aud_cnt = 0;
        run(64);
        check_val("idle_fs_count",  32'(fs_cnt),  32'd8);
        check_val("idle_aud_count", 32'(aud_cnt), 32'd0);

        // Single voice, hp=3: rises after tick at clock 11, falls 12 later
        do_reset();
        regs[0] = 16'h8003;
        find_edge(0, 1'b1, 40, at);
        check_val("v0_first_rise", 32'(at), 32'd11);
        find_edge(0, 1'b0, 40, at);
        check_val("v0_first_fall", 32'(at), 32'd23);
        run(48);

        // All voices in phase at hp=1: level 8 latched every frame
        do_reset();
        for (int i = 0; i < 8; i++) regs[i] = 16'h8001;
        run(8);
        aud_cnt = 0;
        run(32);
        check_val("full_level_aud", 32'(aud_cnt), 32'd32);

        // Lowering hp below cnt toggles on the very next tick
        do_reset();
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        regs[2] = 16'h8000 | 16'd100;
        run(200);
        regs[2] = 16'h8000 | 16'd10;
        find_edge(2, 1'b1, 20, at);
        check_val("v2_shrink_rise", 32'(at), 32'd203);
        find_edge(2, 1'b0, 60, at);
        check_val("v2_shrink_fall", 32'(at), 32'd243);

        // Disable silences next clock; re-enable restarts counting from 0
        do_reset();
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        regs[5] = 16'h8004;
        find_edge(5, 1'b1, 40, at);
        check_val("v5_first_rise", 32'(at), 32'd15);
        run(32);
        regs[5] = 16'h0004;
        step();
        check_val("v5_disabled", 32'(voice_active[5]), 32'd0);
        run(8);
        regs[5] = 16'h8004;
        find_edge(5, 1'b1, 30, at);
        check_val("v5_reenable_rise", 32'(at), 32'd71);

        // Mid-frame reset with three voices running
        do_reset();
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        regs[0] = 16'h8001;
        regs[1] = 16'h8002;
        regs[3] = 16'h8003;
        run(21);
        do_reset();
        find_edge(0, 1'b1, 10, at);
        check_val("post_rst_first_tick", 32'(at), 32'd3);
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
